// File: rtl/mux2.sv
// 2:1 selector with a zero-latency combinational output and a registered copy
// carrying a valid flag and a saturating count of select changes between captures.
module mux2 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] sel_switches
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             sel_prev_q, sel_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign out = sel ? b : a;

    // valid_q doubles as the "a prior capture has happened" flag for switch counting.
    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        sel_prev_d = sel_prev_q;
        cnt_d      = cnt_q;
        if (en) begin
            data_d     = out;
            valid_d    = 1'b1;
            sel_prev_d = sel;
            if (valid_q && (sel != sel_prev_q) && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            sel_prev_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            data_q     <= data_d;
            valid_q    <= valid_d;
            sel_prev_q <= sel_prev_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_q        = data_q;
    assign out_valid    = valid_q;
    assign sel_switches = cnt_q;

endmodule

// File: tb/tb_mux2.sv
// Directed bench for mux2: a WIDTH=1 instance for the truth table, a WIDTH=8
// instance for the registered path, and a CNT_W=2 instance for saturation.
module tb_mux2;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic       en;
    logic       a1, b1;
    logic [7:0] a8, b8;

    logic       out1, out_q1, valid1;
    logic [7:0] sw1;
    logic [7:0] out8, out_q8;
    logic       valid8;
    logic [7:0] sw8;
    logic [7:0] out_s, out_q_s;
    logic       valid_s;
    logic [1:0] sw_s;

    int checks   = 0;
    int failures = 0;

    logic [7:0] tt_exp = 8'b1101_1000;
    logic [4:0] sw_seq = 5'b11011;
    logic [7:0] exp_q8;
    logic [7:0] exp_sw8;
    logic [1:0] exp_sw_s;
    logic       prev_sel;

    mux2 #(.WIDTH(1), .CNT_W(8)) u_w1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .sel(sel), .en(en),
        .out(out1), .out_q(out_q1), .out_valid(valid1), .sel_switches(sw1)
    );

    mux2 #(.WIDTH(8), .CNT_W(8)) u_w8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .sel(sel), .en(en),
        .out(out8), .out_q(out_q8), .out_valid(valid8), .sel_switches(sw8)
    );

    mux2 #(.WIDTH(8), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .sel(sel), .en(en),
        .out(out_s), .out_q(out_q_s), .out_valid(valid_s), .sel_switches(sw_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge; outputs checked before the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sel = 1'b0;
        a1 = 1'b0; b1 = 1'b0; a8 = 8'h11; b8 = 8'h22;
        #12;
        check("rst_out_q",     32'(out_q8), 32'h0);
        check("rst_valid",     32'(valid8), 32'h0);
        check("rst_sw",        32'(sw8),    32'h0);
        check("rst_out_live",  32'(out8),   32'h11);
        sel = 1'b1; #1;
        check("rst_out_live_b", 32'(out8),  32'h22);

        // Combinational truth table, order {a,b,sel} = 000..111
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            {a1, b1, sel} = v;
            #5;
            check($sformatf("tt_%0d", i), 32'(out1), 32'(tt_exp[i]));
        end

        // Release reset between edges, then first capture
        @(negedge clk);
        rst = 1'b0; en = 1'b1; a8 = 8'hA5; b8 = 8'h3C; sel = 1'b0;
        #1;
        check("pre_edge_valid", 32'(valid8), 32'h0);
        step();
        check("lat_out_q",  32'(out_q8), 32'hA5);
        check("lat_valid",  32'(valid8), 32'h1);
        check("lat_sw",     32'(sw8),    32'h0);
        sel = 1'b1; #1;
        check("lat_out_comb", 32'(out8),   32'h3C);
        check("lat_out_q_hold", 32'(out_q8), 32'hA5);
        step();
        check("lat_out_q2", 32'(out_q8), 32'h3C);
        check("lat_sw2",    32'(sw8),    32'h1);

        // Enable low: registers hold, combinational output tracks
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sel = ~sel;
            a8  = 8'h10 + 8'(i);
            b8  = 8'hE0 + 8'(i);
            #1;
            check($sformatf("hold_out_%0d", i), 32'(out8), 32'(sel ? b8 : a8));
            step();
            check($sformatf("hold_q_%0d", i),  32'(out_q8), 32'h3C);
            check($sformatf("hold_v_%0d", i),  32'(valid8), 32'h1);
            check($sformatf("hold_sw_%0d", i), 32'(sw8),    32'h1);
        end

        // One more switch so out_q=3C and sel_switches=2 (last captured sel was 1)
        en = 1'b1; sel = 1'b0; a8 = 8'h3C; b8 = 8'hC3;
        step();
        check("pre_rst_q",  32'(out_q8), 32'h3C);
        check("pre_rst_sw", 32'(sw8),    32'h2);

        // Asynchronous reset between edges
        #2; rst = 1'b1; #1;
        check("arst_q",   32'(out_q8), 32'h0);
        check("arst_v",   32'(valid8), 32'h0);
        check("arst_sw",  32'(sw8),    32'h0);
        check("arst_out", 32'(out8),   32'h3C);
        step();
        check("arst_edge_q", 32'(out_q8), 32'h0);
        check("arst_edge_v", 32'(valid8), 32'h0);

        // Switch counting: sel 1,1,0,1,1, first capture not counted
        @(negedge clk);
        rst = 1'b0;
        exp_sw8 = 8'h0;
        for (int i = 0; i < 5; i++) begin
            sel = sw_seq[i];
            a8  = 8'h40 + 8'(i);
            b8  = 8'h80 + 8'(i);
            exp_q8 = sel ? b8 : a8;
            if (i > 0 && sel != prev_sel) exp_sw8 = exp_sw8 + 8'h1;
            prev_sel = sel;
            step();
            check($sformatf("cnt_q_%0d", i),  32'(out_q8), 32'(exp_q8));
            check($sformatf("cnt_sw_%0d", i), 32'(sw8),    32'(exp_sw8));
        end
        check("cnt_final", 32'(sw8), 32'h2);

        // Saturation: alternate sel for 6 edges after a fresh reset
        #2; rst = 1'b1; #1;
        check("sat_rst", 32'(sw_s), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        exp_sw_s = 2'd0;
        exp_sw8  = 8'h0;
        for (int i = 0; i < 6; i++) begin
            sel = 1'(i % 2);
            if (i > 0) begin
                exp_sw8 = exp_sw8 + 8'h1;
                if (exp_sw_s != 2'd3) exp_sw_s = exp_sw_s + 2'd1;
            end
            step();
            check($sformatf("sat_sw_%0d", i), 32'(sw_s), 32'(exp_sw_s));
            check($sformatf("w8_sw_%0d", i),  32'(sw8),  32'(exp_sw8));
        end
        check("sat_final", 32'(sw_s), 32'h3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux2.md
Name: mux2

Overview:
- 2:1 selector block.
- `out` is the purely combinational selection of input `a` (when `sel`=0) or input `b` (when `sel`=1).
- A registered copy of the selection is also provided, with a valid flag and a saturating select-switch counter, for use in clocked datapaths and debug.
- Sits between datapath sources and downstream logic that needs either a zero-latency or a one-cycle-registered selected value.

Parameters:
- WIDTH, 1, bit width of `a`, `b`, `out`, `out_q`.
- CNT_W, 8, bit width of the `sel_switches` counter.

Ports:
- clk  input  1  rising-edge clock for all registered outputs
- rst  input  1  reset, asynchronous, active-high
- a  input  WIDTH  data input selected when `sel`=0
- b  input  WIDTH  data input selected when `sel`=1
- sel  input  1  select: 0 -> `a`, 1 -> `b`
- en  input  1  capture enable for registered outputs
- out  output  WIDTH  combinational selected value
- out_q  output  WIDTH  registered selected value
- out_valid  output  1  high once `out_q` holds a captured value
- sel_switches  output  CNT_W  count of enabled captures where `sel` changed

Interface note: one clock (`clk`); reset `rst` is asynchronous and active-high, fixed.

Behaviour:
- Combinational path:
  - `out` = `sel` ? `b` : `a`, bitwise across WIDTH, zero latency.
  - Independent of `clk`, `rst` and `en`; `out` stays valid during reset.
- Truth table (WIDTH=1), written a,b,sel -> out:
  - 000->0, 001->0, 010->0, 011->1
  - 100->1, 101->0, 110->1, 111->1
- Reset (`rst`=1, asynchronous, takes effect immediately regardless of `clk`):
  - `out_q`=0, `out_valid`=0, `sel_switches`=0.
  - Internal last-captured select `sel_prev`=0, internal first-capture flag cleared.
  - All held while `rst`=1.
- Registered path, on rising `clk` with `rst`=0 and `en`=1:
  - `out_q` <= (`sel` ? `b` : `a`) sampled at the edge; one-cycle latency.
  - `out_valid` <= 1, and it stays 1 until the next reset.
  - `sel_prev` <= `sel`.
  - If a prior enabled capture has occurred since reset and `sel` != `sel_prev`, then `sel_switches` <= `sel_switches`+1.
  - `sel_switches` saturates at 2^CNT_W-1 and never wraps.
  - The first enabled capture after reset never counts as a switch.
- `en`=0 at a rising edge: all registers hold their values.
- Reset mid-operation: registered outputs clear asynchronously.
  - The first enabled edge after `rst` deasserts behaves as the first capture.
- Inputs change between edges: only `out` follows; `out_q` reflects values at the edge only.
- Simultaneous `rst`=1 and clock edge: reset wins.

Test Plan:
- Combinational truth table: WIDTH=1, drive all 8 {a,b,sel} combos with 5 time units settle each -> `out` matches 0,0,0,1,1,0,1,1 in order 000..111.
- Registered latency: WIDTH=8, rst low, en=1, a=8'hA5, b=8'h3C, sel=0, clock edge -> `out_q`=8'hA5, `out_valid`=1; set sel=1 -> `out`=8'h3C immediately, `out_q` updates to 8'h3C only after the next edge.
- Enable hold: en=0, toggle sel and data across 3 edges -> `out_q`, `out_valid`, `sel_switches` unchanged while `out` tracks the inputs.
- Switch counting: after reset, en=1, sel sequence 1,1,0,1,1 over 5 edges -> `sel_switches`=2, with the first capture not counted.
- Saturation: CNT_W=2, alternate sel every enabled edge for 6 edges -> `sel_switches` stops at 3 and does not wrap.
- Asynchronous reset mid-operation: assert rst between edges with `out_q`=8'h3C and `sel_switches`=2 -> immediately `out_q`=0, `out_valid`=0, `sel_switches`=0, `out` still equals the selected input.
